// File: rtl/add_seq_pkg.sv
// Shared state encoding, default geometry and sizing helpers for the slice-serial adder.
// Purely declarative: no latency, no backpressure.
package add_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // Keeps the slice index at least one bit wide when WIDTH == SLICE.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_sequencer_if.sv
// Request/grant/result bundle between two requesters and the slice-serial adder.
// Wires only: no latency; requesters hold req and operands until their gnt.
interface add_sequencer_if
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             req_0;
    logic             req_1;
    logic [WIDTH-1:0] a_0;
    logic [WIDTH-1:0] b_0;
    logic [WIDTH-1:0] a_1;
    logic [WIDTH-1:0] b_1;
    logic             cin_0;
    logic             cin_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req_0, req_1, a_0, b_0, a_1, b_1, cin_0, cin_1,
        input  gnt_0, gnt_1, busy, done, done_id, sum, cout
    );

    modport slave (
        input  req_0, req_1, a_0, b_0, a_1, b_1, cin_0, cin_1,
        output gnt_0, gnt_1, busy, done, done_id, sum, cout
    );

endinterface

// File: rtl/adder_slice.sv
// SLICE-bit ripple-carry adder with carry in/out; purely combinational, zero latency.
// No backpressure: result follows inputs within the same cycle.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/add_sequencer.sv
// Two-requester round-robin adder computing WIDTH bits one SLICE per cycle; done WIDTH/SLICE edges after gnt.
// Backpressure: requests are only sampled in IDLE, so a requester holds req/operands until its gnt.
module add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic           clk,
    input logic           rst,
    add_sequencer_if.slave io
);

    localparam int NSLICE = num_slices(WIDTH, SLICE);
    localparam int IDX_W  = idx_bits(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             gnt_0_q, gnt_0_d;
    logic             gnt_1_q, gnt_1_d;
    logic             busy_q, busy_d;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_co;
    logic             win;

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_co)
    );

    // On a tie the requester that was not granted last wins.
    assign win = (io.req_0 && io.req_1) ? ~last_q : io.req_1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        id_d      = id_q;
        last_d    = last_q;
        gnt_0_d   = 1'b0;
        gnt_1_d   = 1'b0;
        sl_a      = a_q[idx_q*SLICE +: SLICE];
        sl_b      = b_q[idx_q*SLICE +: SLICE];

        case (state_q)
            IDLE: begin
                if (io.req_0 || io.req_1) begin
                    state_d = ADD;
                    idx_d   = '0;
                    id_d    = win;
                    last_d  = win;
                    a_d     = win ? io.a_1 : io.a_0;
                    b_d     = win ? io.b_1 : io.b_0;
                    carry_d = win ? io.cin_1 : io.cin_0;
                    acc_d   = '0;
                    gnt_0_d = ~win;
                    gnt_1_d = win;
                end
            end
            ADD: begin
                acc_d[idx_q*SLICE +: SLICE] = sl_s;
                carry_d = sl_co;
                idx_d   = idx_q + IDX_W'(1);
                // Partial slices live only in acc; sum is published once, with done.
                if (idx_q == LAST_IDX) begin
                    state_d   = DONE;
                    sum_d     = acc_d;
                    cout_d    = sl_co;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            gnt_0_q   <= 1'b0;
            gnt_1_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            id_q      <= id_d;
            last_q    <= last_d;
            gnt_0_q   <= gnt_0_d;
            gnt_1_q   <= gnt_1_d;
            busy_q    <= busy_d;
        end
    end

    assign io.gnt_0   = gnt_0_q;
    assign io.gnt_1   = gnt_1_q;
    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.done_id = done_id_q;
    assign io.sum     = sum_q;
    assign io.cout    = cout_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: transaction-level timing model plus directed and random requesters.
// Compares every DUT output each cycle, with literal pins on the directed results.
module tb_add_sequencer;
    import add_seq_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int S = DEF_SLICE;
    localparam int N = W / S;

    logic clk = 1'b0;
    logic rst = 1'b0;

    add_sequencer_if #(.WIDTH(W)) io ();

    add_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an op granted at edge g finishes (done) at edge g+N, and the next
    // arbitration is possible at edge g+N+2. Results are plain full-width sums.
    int         cyc        = 0;
    int         free_at    = 0;
    int         busy_until = -1;
    int         done_at    = -1;
    bit         last_g     = 1'b1;
    bit         pid        = 1'b0;
    logic [W:0] pres       = '0;
    logic       e_g0 = 1'b0, e_g1 = 1'b0, e_done = 1'b0, e_id = 1'b0, e_cout = 1'b0;
    logic [W-1:0] e_sum = '0;
    int         gnt_log[$];

    always @(posedge clk) begin
        bit w;
        cyc++;
        if (rst) begin
            free_at = 0; busy_until = -1; done_at = -1; last_g = 1'b1;
            e_g0 = 1'b0; e_g1 = 1'b0; e_done = 1'b0; e_id = 1'b0; e_sum = '0; e_cout = 1'b0;
        end else begin
            e_g0 = 1'b0; e_g1 = 1'b0; e_done = 1'b0;
            if (cyc >= free_at && (io.req_0 || io.req_1)) begin
                w = (io.req_0 && io.req_1) ? !last_g : io.req_1;
                last_g = w;
                pid    = w;
                pres   = w ? ({1'b0, io.a_1} + {1'b0, io.b_1} + (W+1)'(io.cin_1))
                           : ({1'b0, io.a_0} + {1'b0, io.b_0} + (W+1)'(io.cin_0));
                free_at    = cyc + N + 2;
                busy_until = cyc + N;
                done_at    = cyc + N;
                e_g0 = !w;
                e_g1 = w;
            end
            if (cyc == done_at) begin
                e_done = 1'b1;
                e_sum  = pres[W-1:0];
                e_cout = pres[W];
                e_id   = pid;
            end
        end
        #1;
        chk("gnt_0",   32'(io.gnt_0),   32'(e_g0));
        chk("gnt_1",   32'(io.gnt_1),   32'(e_g1));
        chk("done",    32'(io.done),    32'(e_done));
        chk("done_id", 32'(io.done_id), 32'(e_id));
        chk("sum",     32'(io.sum),     32'(e_sum));
        chk("cout",    32'(io.cout),    32'(e_cout));
        chk("busy",    32'(io.busy),    32'(cyc <= busy_until));
        chk("gnt_done_excl", 32'(io.done & (io.gnt_0 | io.gnt_1)), 32'(0));
        if (io.gnt_0) gnt_log.push_back(0);
        if (io.gnt_1) gnt_log.push_back(1);
    end

    task automatic set_req(input bit id, input logic r, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c);
        if (id) begin
            io.req_1 = r; io.a_1 = a; io.b_1 = b; io.cin_1 = c;
        end else begin
            io.req_0 = r; io.a_0 = a; io.b_0 = b; io.cin_0 = c;
        end
    endtask

    // One directed op; operand a is replaced one cycle after the grant.
    task automatic run_op(input string nm, input bit id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c, input logic [W-1:0] a_after,
                          input logic [W-1:0] xs, input logic xc);
        int n;
        int t_g;
        bit seen;
        logic [W-1:0] sum_at_gnt;
        @(negedge clk);
        set_req(id, 1'b1, a, b, c);
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            seen = id ? io.gnt_1 : io.gnt_0;
        end
        chk({nm, "_gnt_seen"}, 32'(seen), 32'(1));
        t_g = cyc;
        sum_at_gnt = io.sum;
        @(negedge clk);
        if (id) io.req_1 = 1'b0; else io.req_0 = 1'b0;
        @(negedge clk);
        if (id) io.a_1 = a_after; else io.a_0 = a_after;
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            seen = io.done;
            if (!seen) chk({nm, "_sum_held"}, 32'(io.sum), 32'(sum_at_gnt));
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'(1));
        chk({nm, "_latency"}, 32'(cyc - t_g), 32'(4));
        chk({nm, "_sum"},     32'(io.sum),     32'(xs));
        chk({nm, "_cout"},    32'(io.cout),    32'(xc));
        chk({nm, "_done_id"}, 32'(io.done_id), 32'(id));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int ndone;
        bit seen;
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op("single", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h1234, 16'h5555, 1'b0);
        run_op("chain",  1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        run_op("stable", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'hFFFF, 16'h0002, 1'b0);

        // Reset during the second ADD cycle aborts the op.
        @(negedge clk);
        set_req(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0);
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            seen = io.gnt_1;
        end
        chk("abort_gnt_seen", 32'(seen), 32'(1));
        @(negedge clk);
        io.req_1 = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_busy",  32'(io.busy),  32'(0));
        chk("async_rst_done",  32'(io.done),  32'(0));
        chk("async_rst_sum",   32'(io.sum),   32'(0));
        chk("async_rst_cout",  32'(io.cout),  32'(0));
        chk("async_rst_gnt",   32'(io.gnt_0 | io.gnt_1), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(io.done), 32'(0));
        end
        chk("abort_sum",  32'(io.sum),  32'(0));
        chk("abort_cout", 32'(io.cout), 32'(0));
        run_op("after_rst", 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h00FF, 16'h0100, 1'b0);

        // Both requesters held from reset: strict alternation starting with 0.
        @(negedge clk);
        rst = 1'b1;
        set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        set_req(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1);
        @(negedge clk);
        gnt_log.delete();
        rst = 1'b0;
        ndone = 0; n = 0;
        while (ndone < 4 && n < 80) begin
            @(negedge clk); n++;
            if (io.done) begin
                ndone++;
                if (io.done_id) begin
                    chk("arb_sum_1",  32'(io.sum),  32'(16'h0001));
                    chk("arb_cout_1", 32'(io.cout), 32'(1));
                end else begin
                    chk("arb_sum_0",  32'(io.sum),  32'(16'h3333));
                    chk("arb_cout_0", 32'(io.cout), 32'(0));
                end
            end
            if (gnt_log.size() >= 4) begin
                io.req_0 = 1'b0;
                io.req_1 = 1'b0;
            end
        end
        chk("arb_ndone", 32'(ndone), 32'(4));
        chk("arb_ngnt",  32'(gnt_log.size()), 32'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("arb_order_%0d", k),
                32'((k < gnt_log.size()) ? gnt_log[k] : 9), 32'(k % 2));
        end
        repeat (4) @(negedge clk);

        // Random requesters that obey the hold-until-grant rule.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (io.req_0 && io.gnt_0) io.req_0 = 1'b0;
            if (io.req_1 && io.gnt_1) io.req_1 = 1'b0;
            if (!io.req_0) begin
                io.a_0 = W'($urandom); io.b_0 = W'($urandom); io.cin_0 = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) io.req_0 = 1'b1;
            end
            if (!io.req_1) begin
                io.a_1 = W'($urandom); io.b_1 = W'($urandom); io.cin_1 = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) io.req_1 = 1'b1;
            end
            if (k % 150 == 77) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        io.req_0 = 1'b0;
        io.req_1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
